// File: rtl/id_ex_alu_issue.sv
// ID/EX boundary register with ALU-control decode and EX-stage forwarding muxes.
// Optional: define ILLEGAL_ALU_OP_TRAP_EN to turn illegal decodes into flagged bubbles.
module id_ex_alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            op5,
    input  logic            alu_src_b,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] ex_mem_result,
    input  logic [XLEN-1:0] mem_wb_result,
    output logic [XLEN-1:0] src_a,
    output logic [XLEN-1:0] src_b,
    output logic [2:0]      alu_control,
    output logic [XLEN-1:0] store_data,
    output logic            valid_out,
    output logic            illegal_op
);

    typedef struct packed {
        logic            valid;
        logic [2:0]      ctrl;
        logic            src_b_imm;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
    } idex_t;

    idex_t           q, d;
    logic [2:0]      ctrl_dec;
    logic            illegal_dec;
    logic [XLEN-1:0] fwd_a, fwd_b;

    always_comb begin
        ctrl_dec    = 3'b010;
        illegal_dec = 1'b0;
        unique case (alu_op)
            2'b00: ctrl_dec = 3'b010;
            2'b01: ctrl_dec = 3'b110;
            2'b10: begin
                unique case (funct3)
                    3'b000:  ctrl_dec = (op5 && funct7b5) ? 3'b110 : 3'b010;
                    3'b010:  ctrl_dec = 3'b100;
                    3'b100:  ctrl_dec = 3'b011;
                    3'b110:  ctrl_dec = 3'b001;
                    3'b111:  ctrl_dec = 3'b000;
                    default: illegal_dec = 1'b1;
                endcase
            end
            default: illegal_dec = 1'b1;
        endcase
    end

    always_comb begin
        d.valid     = valid_in;
        d.ctrl      = ctrl_dec;
        d.src_b_imm = alu_src_b;
        d.rs1       = rs1_data;
        d.rs2       = rs2_data;
        d.imm       = imm;
        if (illegal_dec) begin
`ifdef ILLEGAL_ALU_OP_TRAP_EN
            d.valid = 1'b0;
            d.ctrl  = 3'b000;
`else
            // 111 is an unused ALU code; the ALU drives 0 for it
            d.ctrl  = 3'b111;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (flush)
            q <= '0;
        else if (!stall)
            q <= d;
    end

`ifdef ILLEGAL_ALU_OP_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_op <= 1'b0;
        else if (!flush && !stall && valid_in && illegal_dec)
            illegal_op <= 1'b1;
    end
`else
    assign illegal_op = 1'b0;
`endif

    // Selects apply to held values every cycle, so a stalled entry tracks select changes
    always_comb begin
        unique case (forward_a)
            2'b01:   fwd_a = mem_wb_result;
            2'b10:   fwd_a = ex_mem_result;
            default: fwd_a = q.rs1;
        endcase
        unique case (forward_b)
            2'b01:   fwd_b = mem_wb_result;
            2'b10:   fwd_b = ex_mem_result;
            default: fwd_b = q.rs2;
        endcase
    end

    assign src_a       = fwd_a;
    assign store_data  = fwd_b;
    assign src_b       = q.src_b_imm ? q.imm : fwd_b;
    assign alu_control = q.ctrl;
    assign valid_out   = q.valid;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue; honours ILLEGAL_ALU_OP_TRAP_EN like the design.
module tb_id_ex_alu_issue;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in, stall, flush;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7b5, op5, alu_src_b;
    logic [1:0]      forward_a, forward_b;
    logic [XLEN-1:0] ex_mem_result, mem_wb_result;
    logic [XLEN-1:0] src_a, src_b, store_data;
    logic [2:0]      alu_control;
    logic            valid_out, illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            valid;
        logic [2:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] sd;
        logic            ill;
    } exp_t;

    exp_t sb[$];

`ifdef ILLEGAL_ALU_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    id_ex_alu_issue #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_op(alu_op),
        .funct3(funct3), .funct7b5(funct7b5), .op5(op5), .alu_src_b(alu_src_b),
        .forward_a(forward_a), .forward_b(forward_b),
        .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
        .src_a(src_a), .src_b(src_b), .alu_control(alu_control),
        .store_data(store_data), .valid_out(valid_out), .illegal_op(illegal_op)
    );

    task automatic set_in(input logic v, input logic [1:0] op, input logic [2:0] f3,
                          input logic f7, input logic o5, input logic [XLEN-1:0] r1,
                          input logic [XLEN-1:0] r2, input logic [XLEN-1:0] im,
                          input logic sb_imm);
        valid_in = v; alu_op = op; funct3 = f3; funct7b5 = f7; op5 = o5;
        rs1_data = r1; rs2_data = r2; imm = im; alu_src_b = sb_imm;
    endtask

    task automatic push(input logic v, input logic [2:0] c, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] sd, input logic ill);
        exp_t e;
        e.valid = v; e.ctrl = c; e.a = a; e.b = b; e.sd = sd; e.ill = ill;
        sb.push_back(e);
    endtask

    // Compare current outputs with the oldest scoreboard entry
    task automatic compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks += 6;
        if (valid_out !== e.valid) begin errors++;
            $display("FAIL %s valid_out: got %b want %b", name, valid_out, e.valid); end
        if (alu_control !== e.ctrl) begin errors++;
            $display("FAIL %s alu_control: got %b want %b", name, alu_control, e.ctrl); end
        if (src_a !== e.a) begin errors++;
            $display("FAIL %s src_a: got %h want %h", name, src_a, e.a); end
        if (src_b !== e.b) begin errors++;
            $display("FAIL %s src_b: got %h want %h", name, src_b, e.b); end
        if (store_data !== e.sd) begin errors++;
            $display("FAIL %s store_data: got %h want %h", name, store_data, e.sd); end
        if (illegal_op !== e.ill) begin errors++;
            $display("FAIL %s illegal_op: got %b want %b", name, illegal_op, e.ill); end
    endtask

    task automatic clock_and_compare(input string name);
        @(posedge clk); #1;
        compare(name);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = $urandom_range(1); flush = $urandom_range(1);
        set_in(1'b1, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
               $urandom, $urandom, $urandom, 1'($urandom));
        forward_a = 2'b00; forward_b = 2'b00;
        ex_mem_result = $urandom; mem_wb_result = $urandom;
        repeat (3) @(negedge clk);
        push(0, 3'b000, 0, 0, 0, 0);
        compare("reset_hold");
        stall = 0; flush = 0;
        rst_n = 1'b1; #1;
        push(0, 3'b000, 0, 0, 0, 0);
        compare("reset_release");
        @(negedge clk);
    endtask

    task automatic test_rtype_sub();
        set_in(1, 2'b10, 3'b000, 1, 1, 32'h10, 32'h3, 32'h1234, 0);
        push(1, 3'b110, 32'h10, 32'h3, 32'h3, 0);
        clock_and_compare("rtype_sub");
    endtask

    task automatic test_addi();
        set_in(1, 2'b10, 3'b000, 1, 0, 32'h5, 32'h7, 32'hFFFF_FFFF, 1);
        push(1, 3'b010, 32'h5, 32'hFFFF_FFFF, 32'h7, 0);
        clock_and_compare("addi");
    endtask

    task automatic test_forwarding();
        ex_mem_result = 32'hAAAA_0000; mem_wb_result = 32'h0000_5555;
        forward_a = 2'b10; forward_b = 2'b01;
        set_in(1, 2'b00, 3'b010, 0, 0, 32'h11, 32'h22, 32'h40, 0);
        push(1, 3'b010, 32'hAAAA_0000, 32'h5555, 32'h5555, 0);
        clock_and_compare("fwd_exmem_memwb");
        forward_a = 2'b11; forward_b = 2'b10; #1;
        push(1, 3'b010, 32'h11, 32'hAAAA_0000, 32'hAAAA_0000, 0);
        compare("fwd_a11_b10");
        forward_a = 2'b01; forward_b = 2'b11; #1;
        push(1, 3'b010, 32'h5555, 32'h22, 32'h22, 0);
        compare("fwd_a01_b11");
        forward_a = 2'b00; forward_b = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_stall_flush();
        set_in(1, 2'b10, 3'b110, 0, 1, 32'h1, 32'h2, 32'h3, 0);
        push(1, 3'b001, 32'h1, 32'h2, 32'h2, 0);
        clock_and_compare("or_capture");
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            set_in(1, 2'b10, 3'b111, 0, 1, 32'hDEAD_0000 + i, 32'hBEEF, 32'h77, 1);
            push(1, 3'b001, 32'h1, 32'h2, 32'h2, 0);
            clock_and_compare("stall_hold");
        end
        // Held entry re-muxed under a new select
        forward_a = 2'b10; ex_mem_result = 32'h0BAD_F00D; #1;
        push(1, 3'b001, 32'h0BAD_F00D, 32'h2, 32'h2, 0);
        compare("stall_fwd_change");
        forward_a = 2'b00;
        flush = 1;
        push(0, 3'b000, 0, 0, 0, 0);
        clock_and_compare("stall_and_flush");
        stall = 0; flush = 0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] want [8];
        logic       bad  [8];
        want = '{3'b010, 3'b111, 3'b100, 3'b111, 3'b011, 3'b111, 3'b001, 3'b000};
        bad  = '{0, 1, 0, 1, 0, 1, 0, 0};
        for (int f = 0; f < 8; f++) begin
            logic [XLEN-1:0] r1, r2;
            r1 = $urandom; r2 = $urandom;
            // valid_in=0 so the trap flag is never raised here
            set_in(0, 2'b10, 3'(f), 0, 1, r1, r2, 32'h0, 0);
            push(0, (bad[f] && TRAP) ? 3'b000 : want[f], r1, r2, r2, 0);
            clock_and_compare("funct3_sweep");
        end
        set_in(1, 2'b01, 3'b101, 1, 1, 32'h9, 32'hA, 32'h0, 0);
        push(1, 3'b110, 32'h9, 32'hA, 32'hA, 0);
        clock_and_compare("branch_sub");
    endtask

    task automatic test_illegal();
        set_in(1, 2'b10, 3'b001, 0, 1, 32'h9, 32'h8, 32'h0, 0);
        push(!TRAP, TRAP ? 3'b000 : 3'b111, 32'h9, 32'h8, 32'h8, TRAP);
        clock_and_compare("illegal_f3_001");
        set_in(1, 2'b00, 3'b000, 0, 0, 32'h4, 32'h6, 32'h100, 1);
        push(1, 3'b010, 32'h4, 32'h100, 32'h6, TRAP);
        clock_and_compare("illegal_sticky");
        set_in(1, 2'b11, 3'b000, 0, 0, 32'h1, 32'h2, 32'h0, 0);
        push(!TRAP, TRAP ? 3'b000 : 3'b111, 32'h1, 32'h2, 32'h2, TRAP);
        clock_and_compare("illegal_aluop11");
        flush = 1;
        push(0, 3'b000, 0, 0, 0, TRAP);
        clock_and_compare("illegal_after_flush");
        flush = 0;
    endtask

    task automatic test_reset_mid_stall();
        set_in(1, 2'b10, 3'b100, 0, 1, 32'h33, 32'h44, 32'h0, 0);
        push(1, 3'b011, 32'h33, 32'h44, 32'h44, TRAP);
        clock_and_compare("xor_capture");
        stall = 1;
        #2 rst_n = 0; #1;
        push(0, 3'b000, 0, 0, 0, 0);
        compare("reset_mid_stall");
        @(negedge clk);
        stall = 0; rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_addi();
        test_forwarding();
        test_stall_flush();
        test_back_to_back();
        test_illegal();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
